// File: rtl/usb_rx_bitstream.sv
// USB receive bitstream front end: line-state and NRZI decode, bit unstuffing,
// SYNC hunt, PID capture and a saturating count of received data bits.
module usb_rx_bitstream (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dp_in,
    input  logic        dm_in,
    input  logic        rec_en,
    input  logic        clr_cnt,
    output logic        in_bit,
    output logic        bit_valid,
    output logic        sync_rec,
    output logic        se0_rec,
    output logic [2:0]  PID_rec,
    output logic [31:0] bit_count,
    output logic        rx_err
);
    typedef enum logic [1:0] {IDLE, HUNT, PID, PAYLOAD} state_t;

    localparam logic [7:0] SYNC_PATTERN = 8'h01;
    // All-ones history cannot contain the seven SYNC zeros, so a fresh hunt
    // needs eight real bits before it can match.
    localparam logic [6:0] HIST_EMPTY   = 7'h7F;

    state_t     state;
    logic       prev_j;
    logic [2:0] ones_cnt;
    logic [6:0] sync_hist;
    logic [6:0] pid_shift;
    logic [2:0] pid_cnt;

    logic       line_j;
    logic       line_se0;
    logic       line_se1;
    logic       is_jk;
    logic       raw_bit;
    logic       stuff_slot;
    logic       active;
    logic       bv_now;
    logic       err_now;
    logic       sync_hit;
    logic       eop_exit;
    logic       in_packet;
    logic [7:0] hist_next;
    logic [7:0] pid_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [2:0] pid_decode(input logic [7:0] b);
        logic [2:0] r;
        r = 3'b000;
        if (b[7:4] == ~b[3:0]) begin
            case (b[3:0])
                4'b0010: r = 3'b001;
                4'b1010: r = 3'b010;
                4'b0011: r = 3'b100;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    assign line_j     = dp_in & ~dm_in;
    assign line_se0   = ~dp_in & ~dm_in;
    assign line_se1   = dp_in & dm_in;
    assign is_jk      = dp_in ^ dm_in;
    // NRZI: no transition means a 1; dp_in alone identifies J vs K here.
    assign raw_bit    = (dp_in == prev_j);
    assign stuff_slot = is_jk && (ones_cnt == 3'd6);
    assign active     = rec_en && (state != IDLE);
    assign bv_now     = active && is_jk && !stuff_slot;
    assign err_now    = active && (line_se1 || (stuff_slot && raw_bit));
    assign hist_next  = {sync_hist, raw_bit};
    assign sync_hit   = (state == HUNT) && bv_now && (hist_next == SYNC_PATTERN);
    assign eop_exit   = se0_rec && line_j;
    assign in_packet  = (state == PID) || (state == PAYLOAD);
    assign pid_next   = {raw_bit, pid_shift};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prev_j    <= 1'b1;
            ones_cnt  <= 3'd0;
            sync_hist <= 7'd0;
            pid_shift <= 7'd0;
            pid_cnt   <= 3'd0;
            in_bit    <= 1'b0;
            bit_valid <= 1'b0;
            sync_rec  <= 1'b0;
            se0_rec   <= 1'b0;
            PID_rec   <= 3'b000;
            bit_count <= 32'd0;
            rx_err    <= 1'b0;
        end else begin
            prev_j    <= is_jk ? dp_in : 1'b1;
            se0_rec   <= line_se0;
            bit_valid <= bv_now;
            in_bit    <= bv_now & raw_bit;
            rx_err    <= err_now;
            sync_rec  <= sync_hit;

            if (!active || !is_jk || stuff_slot || !raw_bit)
                ones_cnt <= 3'd0;
            else
                ones_cnt <= ones_cnt + 3'd1;

            if (clr_cnt || sync_hit)
                bit_count <= 32'd0;
            else if (bv_now && in_packet)
                bit_count <= sat_inc(bit_count);

            if (!rec_en) begin
                state     <= IDLE;
                PID_rec   <= 3'b000;
                sync_hist <= HIST_EMPTY;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= HUNT;
                        PID_rec   <= 3'b000;
                        sync_hist <= HIST_EMPTY;
                    end
                    HUNT: begin
                        if (bv_now)
                            sync_hist <= hist_next[6:0];
                        if (sync_hit) begin
                            state     <= PID;
                            PID_rec   <= 3'b000;
                            pid_shift <= 7'd0;
                            pid_cnt   <= 3'd0;
                        end
                    end
                    default: begin
                        sync_hist <= HIST_EMPTY;
                        if (err_now || eop_exit) begin
                            state <= HUNT;
                        end else if ((state == PID) && bv_now) begin
                            pid_shift <= pid_next[7:1];
                            pid_cnt   <= pid_cnt + 3'd1;
                            if (pid_cnt == 3'd7) begin
                                PID_rec <= pid_decode(pid_next);
                                state   <= PAYLOAD;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule
